// File: rtl/diff_seq_pkg.sv
// Shared constants, FSM state type and output-folding helper for the differential stimulus
// sequencer.
package diff_seq_pkg;

  localparam int unsigned DEF_IN_W  = 79;
  localparam int unsigned DEF_OUT_W = 646;
  localparam int unsigned DEF_SIG_W = 32;
  localparam int unsigned DEF_CNT_W = 16;

  localparam logic [31:0] LFSR_TAPS = 32'hA300_0000;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] SIG_INIT  = 32'hFFFF_FFFF;

  localparam int unsigned FOLD_N = (DEF_OUT_W + DEF_SIG_W - 1) / DEF_SIG_W;

  typedef enum logic [2:0] {
    StIdle,
    StGen,
    StSettle,
    StCapture,
    StHold,
    StDone
  } state_e;

  // XOR of all SIG_W-bit chunks of the response; the top chunk is zero-padded.
  function automatic logic [DEF_SIG_W-1:0] fold_xor(input logic [DEF_OUT_W-1:0] d);
    logic [FOLD_N*DEF_SIG_W-1:0] pad;
    logic [DEF_SIG_W-1:0]        acc;
    pad = '0;
    pad[DEF_OUT_W-1:0] = d;
    acc = '0;
    for (int unsigned c = 0; c < FOLD_N; c++) begin
      acc ^= pad[c*DEF_SIG_W +: DEF_SIG_W];
    end
    return acc;
  endfunction

endpackage

// File: rtl/diff_lfsr32.sv
// 32-bit Galois right-shift LFSR with seed load and step enable; exposes the post-step value
// so the caller can use a word in the same cycle it is generated.
module diff_lfsr32
  import diff_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] next_state
);

  logic [31:0] state_q;

  always_comb begin
    next_state = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_TAPS : 32'h0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= 32'h1;
    end else if (load) begin
      // An all-zero seed would lock the LFSR.
      state_q <= (seed == 32'h0) ? 32'h1 : seed;
    end else if (step) begin
      state_q <= next_state;
    end
  end

endmodule

// File: rtl/diff_stim_sequencer.sv
// Drives pseudo-random vectors into a DUT, samples each response after a settle delay,
// streams it out over valid/ready and folds it into a MISR signature.
module diff_stim_sequencer
  import diff_seq_pkg::*;
#(
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned OUT_W  = DEF_OUT_W,
  parameter int unsigned SIG_W  = DEF_SIG_W,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [31:0]      seed,
  input  logic [CNT_W-1:0] num_vec,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_idx,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature
);

  localparam int unsigned NW  = (IN_W + 31) / 32;
  localparam int unsigned GCW = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e           state_q;
  logic [GCW-1:0]   gen_cnt_q;
  logic [SCW-1:0]   settle_cnt_q;
  logic [NW*32-1:0] gen_buf_q;
  logic [NW*32-1:0] gen_full;
  logic [CNT_W-1:0] num_vec_q;
  logic [CNT_W-1:0] idx_q;
  logic [IN_W-1:0]  dut_in_q;
  logic [OUT_W-1:0] out_data_q;
  logic [SIG_W-1:0] sig_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             done_q;

  logic [31:0] lfsr_next;
  logic        lfsr_load;
  logic        lfsr_step;

  assign lfsr_load = (state_q == StIdle) && start && !abort;
  assign lfsr_step = (state_q == StGen) && !abort;

  diff_lfsr32 u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (lfsr_load),
    .seed       (seed),
    .step       (lfsr_step),
    .next_state (lfsr_next)
  );

  // Word k lands in slot k, so the final word is merged combinationally on the last GEN cycle.
  always_comb begin
    gen_full = gen_buf_q;
    gen_full[{gen_cnt_q, 5'd0} +: 32] = lfsr_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      gen_cnt_q    <= '0;
      settle_cnt_q <= '0;
      gen_buf_q    <= '0;
      num_vec_q    <= '0;
      idx_q        <= '0;
      dut_in_q     <= '0;
      out_data_q   <= '0;
      sig_q        <= SIG_INIT[SIG_W-1:0];
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q     <= StIdle;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              num_vec_q <= num_vec;
              sig_q     <= SIG_INIT[SIG_W-1:0];
              idx_q     <= '0;
              gen_cnt_q <= '0;
              if (num_vec == '0) begin
                state_q <= StDone;
              end else begin
                state_q <= StGen;
                busy_q  <= 1'b1;
              end
            end
          end
          StGen: begin
            gen_buf_q <= gen_full;
            if (gen_cnt_q == GCW'(NW - 1)) begin
              dut_in_q     <= gen_full[IN_W-1:0];
              gen_cnt_q    <= '0;
              settle_cnt_q <= '0;
              state_q      <= StSettle;
            end else begin
              gen_cnt_q <= gen_cnt_q + 1'b1;
            end
          end
          StSettle: begin
            if (settle_cnt_q == SCW'(SETTLE - 1)) begin
              state_q <= StCapture;
            end else begin
              settle_cnt_q <= settle_cnt_q + 1'b1;
            end
          end
          StCapture: begin
            out_data_q  <= dut_out;
            out_valid_q <= 1'b1;
            sig_q       <= {sig_q[SIG_W-2:0], 1'b0}
                         ^ (sig_q[SIG_W-1] ? MISR_POLY[SIG_W-1:0] : '0)
                         ^ fold_xor(dut_out);
            state_q     <= StHold;
          end
          StHold: begin
            if (out_ready) begin
              out_valid_q <= 1'b0;
              if (idx_q == num_vec_q - 1'b1) begin
                state_q <= StDone;
                busy_q  <= 1'b0;
              end else begin
                idx_q   <= idx_q + 1'b1;
                state_q <= StGen;
              end
            end
          end
          StDone: begin
            done_q  <= 1'b1;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign dut_in    = dut_in_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_diff_stim_sequencer.sv
// Directed bench for diff_stim_sequencer with a reference LFSR/MISR and a scoreboard of the
// expected vector, response and index for every sample.
module tb_diff_stim_sequencer;

  localparam int unsigned IN_W  = 79;
  localparam int unsigned OUT_W = 646;
  localparam int unsigned SIG_W = 32;
  localparam int unsigned CNT_W = 16;

  typedef logic [OUT_W-1:0] wide_t;

  typedef struct {
    logic [IN_W-1:0]  din;
    logic [OUT_W-1:0] dout;
    logic [CNT_W-1:0] idx;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [31:0]      seed;
  logic [CNT_W-1:0] num_vec;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_idx;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] signature;

  bit   zero_out;
  exp_t sb[$];
  int   checks;
  int   errors;

  diff_stim_sequencer #(
    .IN_W   (IN_W),
    .OUT_W  (OUT_W),
    .SIG_W  (SIG_W),
    .CNT_W  (CNT_W),
    .SETTLE (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .seed      (seed),
    .num_vec   (num_vec),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done),
    .signature (signature)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in DUT: input bits repeated across y, every other copy inverted.
  function automatic logic [OUT_W-1:0] resp(input logic [IN_W-1:0] din);
    logic [OUT_W-1:0] r;
    for (int i = 0; i < int'(OUT_W); i++) begin
      r[i] = din[i % int'(IN_W)] ^ (((i / int'(IN_W)) % 2) == 1);
    end
    return r;
  endfunction

  always_comb begin
    dut_out = zero_out ? '0 : resp(dut_in);
  end

  function automatic logic [31:0] lstep(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 32'hA300_0000;
    return n;
  endfunction

  function automatic logic [IN_W-1:0] vec_from(input logic [31:0] s);
    logic [95:0] cat;
    cat[31:0]  = lstep(s);
    cat[63:32] = lstep(cat[31:0]);
    cat[95:64] = lstep(cat[63:32]);
    return cat[IN_W-1:0];
  endfunction

  function automatic logic [31:0] misr(input logic [31:0] sig, input logic [OUT_W-1:0] d);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < int'(OUT_W); i++) acc[i % 32] = acc[i % 32] ^ d[i];
    return {sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C1_1DB7 : 32'h0) ^ acc;
  endfunction

  task automatic check(input string tag, input wide_t obs, input wide_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Push the expected samples of a run, then pulse start for one edge.
  task automatic launch(input logic [31:0] s, input int n, output logic [31:0] exp_sig);
    logic [31:0] st;
    exp_t        e;
    st      = (s == 32'h0) ? 32'h1 : s;
    exp_sig = 32'hFFFF_FFFF;
    for (int v = 0; v < n; v++) begin
      e.din  = vec_from(st);
      e.dout = zero_out ? '0 : resp(e.din);
      e.idx  = CNT_W'(v);
      sb.push_back(e);
      exp_sig = misr(exp_sig, e.dout);
      st = lstep(lstep(lstep(st)));
    end
    seed    = s;
    num_vec = CNT_W'(n);
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  // Pop/compare every sample until done; mid > 0 pulses a stray start with new settings.
  task automatic consume(input logic [31:0] exp_sig, input int mid, input int budget);
    int   dones;
    int   cyc;
    exp_t e;
    dones = 0;
    cyc   = 0;
    while (dones == 0 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == mid);
      if (cyc == mid) begin
        seed    = 32'h1234_5678;
        num_vec = CNT_W'(7);
      end
      if (out_valid) begin
        check("sample_expected", wide_t'(sb.size() != 0), wide_t'(1));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("out_data", out_data, e.dout);
          check("out_idx", wide_t'(out_idx), wide_t'(e.idx));
          check("dut_in", wide_t'(dut_in), wide_t'(e.din));
        end
      end
      if (done) begin
        dones++;
        check("busy_at_done", wide_t'(busy), wide_t'(0));
      end
    end
    start = 1'b0;
    check("done_pulses", wide_t'(dones), wide_t'(1));
    check("sb_drained", wide_t'(sb.size()), wide_t'(0));
    check("signature", wide_t'(signature), wide_t'(exp_sig));
    @(posedge clk); #1;
    check("done_one_cycle", wide_t'(done), wide_t'(0));
  endtask

  initial begin
    logic [31:0]      sig;
    logic [IN_W-1:0]  din_e;
    logic [OUT_W-1:0] rec_data;
    logic [CNT_W-1:0] rec_idx;
    logic [IN_W-1:0]  rec_din;
    exp_t             e;
    int               cyc;

    checks    = 0;
    errors    = 0;
    zero_out  = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    seed      = '0;
    num_vec   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    check("rst_dut_in", wide_t'(dut_in), wide_t'(0));
    check("rst_out_valid", wide_t'(out_valid), wide_t'(0));
    check("rst_out_data", out_data, wide_t'(0));
    check("rst_out_idx", wide_t'(out_idx), wide_t'(0));
    check("rst_busy", wide_t'(busy), wide_t'(0));
    check("rst_done", wide_t'(done), wide_t'(0));
    check("rst_signature", wide_t'(signature), wide_t'(32'hFFFF_FFFF));

    // Seed 1, one vector: known first vector
    launch(32'h1, 1, sig);
    check("busy_after_start", wide_t'(busy), wide_t'(1));
    consume(sig, 0, 40);
    check("seed1_vector", wide_t'(dut_in), wide_t'(79'h5180_0000_A300_0000));

    // Multi-vector run with a start and num_vec change that must be ignored
    launch(32'hDEAD_BEEF, 4, sig);
    consume(sig, 5, 80);

    // Seed 0 behaves as seed 1
    launch(32'h0, 1, sig);
    consume(sig, 0, 40);
    check("seed0_vector", wide_t'(dut_in), wide_t'(79'h5180_0000_A300_0000));

    // num_vec = 0: straight to done, no samples
    launch(32'h55, 0, sig);
    check("nv0_done_early", wide_t'(done), wide_t'(0));
    @(posedge clk); #1;
    check("nv0_done", wide_t'(done), wide_t'(1));
    check("nv0_busy", wide_t'(busy), wide_t'(0));
    check("nv0_valid", wide_t'(out_valid), wide_t'(0));
    check("nv0_signature", wide_t'(signature), wide_t'(32'hFFFF_FFFF));
    @(posedge clk); #1;
    check("nv0_done_one_cycle", wide_t'(done), wide_t'(0));

    // All-zero responses
    zero_out = 1'b1;
    launch(32'h9, 1, sig);
    consume(sig, 0, 40);
    check("zero_sig_1vec", wide_t'(signature), wide_t'(32'hFB3E_E249));
    launch(32'h9, 2, sig);
    consume(sig, 0, 60);
    zero_out = 1'b0;

    // Backpressure: sample must hold while out_ready is low
    out_ready = 1'b0;
    launch(32'h00C0_FFEE, 2, sig);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_valid_seen", wide_t'(out_valid), wide_t'(1));
    e = sb.pop_front();
    check("bp_data", out_data, e.dout);
    check("bp_idx", wide_t'(out_idx), wide_t'(e.idx));
    rec_data = out_data;
    rec_idx  = out_idx;
    rec_din  = dut_in;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", wide_t'(out_valid), wide_t'(1));
      check("bp_hold_data", out_data, rec_data);
      check("bp_hold_idx", wide_t'(out_idx), wide_t'(rec_idx));
      check("bp_hold_dut_in", wide_t'(dut_in), wide_t'(rec_din));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", wide_t'(out_valid), wide_t'(0));
    consume(sig, 0, 60);

    // Abort while settling
    din_e = vec_from(32'h5);
    seed    = 32'h5;
    num_vec = CNT_W'(3);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", wide_t'(busy), wide_t'(0));
    check("abort_valid", wide_t'(out_valid), wide_t'(0));
    check("abort_dut_in", wide_t'(dut_in), wide_t'(din_e));
    check("abort_signature", wide_t'(signature), wide_t'(32'hFFFF_FFFF));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", wide_t'(done | out_valid | busy), wide_t'(0));
    end

    // Reset in the middle of GEN
    seed    = 32'h7;
    num_vec = CNT_W'(2);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mrst_dut_in", wide_t'(dut_in), wide_t'(0));
    check("mrst_busy", wide_t'(busy), wide_t'(0));
    check("mrst_signature", wide_t'(signature), wide_t'(32'hFFFF_FFFF));
    check("mrst_out_data", out_data, wide_t'(0));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("mrst_no_done", wide_t'(done | out_valid | busy), wide_t'(0));
    end

    // Clean run after reset
    launch(32'h1, 1, sig);
    consume(sig, 0, 40);
    check("post_rst_vector", wide_t'(dut_in), wide_t'(79'h5180_0000_A300_0000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
